button_gesture: RTL and testbench

Classifies presses of one debounced push-button into single-cycle gesture events: short press, double press, long press, and auto-repeat while held. Sits directly downstream of the button debouncer. It consumes the debounced, already-synchronous button level and drives the user-command logic, replacing raw "button went high" pulses with distinct gestures. One instance per physical button.

---
 rtl/button_gesture_pkg.sv | 19 +
 rtl/button_gesture.sv | 129 ++++++++++++
 tb/tb_button_gesture.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/button_gesture_pkg.sv
// Shared types and constants for the push-button gesture classifier.
// Default cycle counts assume a 50 MHz system clock.
package button_pkg;

  localparam int unsigned CNT_W = 32;

  localparam int unsigned DEF_LONG_CYC   = 50_000_000;
  localparam int unsigned DEF_DOUBLE_CYC = 15_000_000;
  localparam int unsigned DEF_REPEAT_CYC = 10_000_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS1,
    ST_HELD,
    ST_GAP,
    ST_PRESS2
  } gesture_state_t;

endpackage

// File: rtl/button_gesture.sv
// Classifies a debounced button level into one-cycle short/double/long/repeat
// gesture pulses. All outputs are registered from next-state logic.
module button_gesture
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYC   = DEF_LONG_CYC,
  parameter int unsigned DOUBLE_CYC = DEF_DOUBLE_CYC,
  parameter int unsigned REPEAT_CYC = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  gesture_state_t   r_state;
  gesture_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  logic r_short, r_double, r_long, r_repeat, r_busy;
  logic w_short, w_double, w_long, w_repeat;

  assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The level is tested before the counter in every state, so a button
  // change on a timeout edge always wins over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_short     = 1'b0;
    w_double    = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (btn_level) begin
          w_state_nxt = ST_PRESS1;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESS1: begin
        if (!btn_level) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
          w_long      = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_HELD: begin
        if (!btn_level) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == REPEAT_LAST) begin
          w_cnt_nxt = '0;
          w_repeat  = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_GAP: begin
        if (btn_level) begin
          w_state_nxt = ST_PRESS2;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DOUBLE_LAST) begin
          w_state_nxt = ST_IDLE;
          w_short     = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_PRESS2: begin
        if (!btn_level) begin
          w_state_nxt = ST_IDLE;
          w_double    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_short  <= w_short;
      r_double <= w_double;
      r_long   <= w_long;
      r_repeat <= w_repeat;
      r_busy   <= (w_state_nxt != ST_IDLE);
    end
  end

  assign short_press  = r_short;
  assign double_press = r_double;
  assign long_press   = r_long;
  assign repeat_pulse = r_repeat;
  assign busy         = r_busy;

endmodule

// File: tb/tb_button_gesture.sv
// Gesture classifier bench: directed scenarios plus random button activity,
// compared each cycle against a timestamp-based reference model.
module tb_button_gesture;

  localparam int unsigned LONG   = 20;
  localparam int unsigned DBL    = 10;
  localparam int unsigned REP    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_level = 1'b0;
  logic short_press, double_press, long_press, repeat_pulse, busy;

  button_gesture #(
    .LONG_CYC  (LONG),
    .DOUBLE_CYC(DBL),
    .REPEAT_CYC(REP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_level   (btn_level),
    .short_press (short_press),
    .double_press(double_press),
    .long_press  (long_press),
    .repeat_pulse(repeat_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: gesture phase plus the edge index at which it began.
  localparam int PH_IDLE = 0, PH_DOWN = 1, PH_HOLD = 2, PH_WAIT = 3, PH_DOWN2 = 4;
  int   ph = PH_IDLE;
  int   n = 0;
  int   t_press = 0, t_rel = 0, t_hold = 0;
  logic e_short = 0, e_double = 0, e_long = 0, e_rep = 0, e_busy = 0;

  // Observation bookkeeping
  int   c_short = 0, c_double = 0, c_long = 0, c_rep = 0;
  int   last_short = -1, last_double = -1, last_long = -1;
  logic prev_any = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic lvl);
    n++;
    e_short = 0; e_double = 0; e_long = 0; e_rep = 0;
    if (rst) begin
      ph = PH_IDLE;
    end else begin
      case (ph)
        PH_IDLE:  if (lvl) begin ph = PH_DOWN; t_press = n; end
        PH_DOWN:
          if (!lvl) begin ph = PH_WAIT; t_rel = n; end
          else if (n - t_press == LONG) begin e_long = 1; ph = PH_HOLD; t_hold = n; end
        PH_HOLD:
          if (!lvl) ph = PH_IDLE;
          else if ((n - t_hold) % REP == 0) e_rep = 1;
        PH_WAIT:
          if (lvl) ph = PH_DOWN2;
          else if (n - t_rel == DBL) begin e_short = 1; ph = PH_IDLE; end
        PH_DOWN2: if (!lvl) begin e_double = 1; ph = PH_IDLE; end
        default: ph = PH_IDLE;
      endcase
    end
    e_busy = (ph != PH_IDLE);
  endtask

  task automatic clear_tally();
    c_short = 0; c_double = 0; c_long = 0; c_rep = 0;
    last_short = -1; last_double = -1; last_long = -1;
  endtask

  // One clock: check outputs of the previous edge, then drive the next input.
  task automatic cycle(input logic lvl, input logic r);
    logic any_now;
    @(negedge clk);
    chk("short_press", short_press, e_short);
    chk("double_press", double_press, e_double);
    chk("long_press", long_press, e_long);
    chk("repeat", repeat_pulse, e_rep);
    chk("busy", busy, e_busy);
    chk("exclusive", ($countones({short_press, double_press, long_press, repeat_pulse}) <= 1), 1'b1);
    any_now = short_press | double_press | long_press | repeat_pulse;
    chk("width", (any_now && prev_any), 1'b0);
    prev_any = any_now;
    if (short_press)  begin c_short++;  last_short  = n; end
    if (double_press) begin c_double++; last_double = n; end
    if (long_press)   begin c_long++;   last_long   = n; end
    if (repeat_pulse) c_rep++;
    btn_level = lvl;
    rst = r;
    model_step(lvl);
  endtask

  task automatic run(input logic lvl, input int cnt);
    for (int i = 0; i < cnt; i++) cycle(lvl, 1'b0);
  endtask

  task automatic expect_counts(input string tag, input int s, input int d, input int l, input int r);
    chk_int({tag, "_short_cnt"}, c_short, s);
    chk_int({tag, "_double_cnt"}, c_double, d);
    chk_int({tag, "_long_cnt"}, c_long, l);
    chk_int({tag, "_repeat_cnt"}, c_rep, r);
  endtask

  initial begin
    int e0, rel, lvl_i, len;
    #1;
    chk("rst_short", short_press, 1'b0);
    chk("rst_double", double_press, 1'b0);
    chk("rst_long", long_press, 1'b0);
    chk("rst_repeat", repeat_pulse, 1'b0);
    chk("rst_busy", busy, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    run(1'b0, 3);

    // Short press
    clear_tally();
    cycle(1'b1, 1'b0); run(1'b1, 4);
    cycle(1'b0, 1'b0); rel = n; run(1'b0, 15);
    expect_counts("short", 1, 0, 0, 0);
    chk_int("short_latency", last_short, rel + DBL);

    // Double press
    clear_tally();
    run(1'b1, 5); run(1'b0, 4); run(1'b1, 3);
    cycle(1'b0, 1'b0); rel = n; run(1'b0, 15);
    expect_counts("double", 0, 1, 0, 0);
    chk_int("double_latency", last_double, rel);

    // Long press with repeat
    clear_tally();
    cycle(1'b1, 1'b0); e0 = n; run(1'b1, 31);
    run(1'b0, 15);
    expect_counts("long", 0, 0, 1, 2);
    chk_int("long_latency", last_long, e0 + LONG);

    // Second press exactly on the gap timeout edge
    clear_tally();
    run(1'b1, 5); run(1'b0, DBL); run(1'b1, 2); run(1'b0, 15);
    expect_counts("gap_race", 0, 1, 0, 0);

    // Release exactly on the long edge
    clear_tally();
    run(1'b1, LONG);
    cycle(1'b0, 1'b0); rel = n; run(1'b0, 15);
    expect_counts("long_race", 1, 0, 0, 0);
    chk_int("long_race_latency", last_short, rel + DBL);

    // Reset in the middle of the gap
    clear_tally();
    run(1'b1, 5); run(1'b0, 3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_short", short_press, 1'b0);
    chk("midrst_double", double_press, 1'b0);
    chk("midrst_long", long_press, 1'b0);
    chk("midrst_repeat", repeat_pulse, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    ph = PH_IDLE;
    e_short = 0; e_double = 0; e_long = 0; e_rep = 0; e_busy = 0;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    run(1'b0, 20);
    expect_counts("midrst", 0, 0, 0, 0);
    clear_tally();
    run(1'b1, 4); run(1'b0, 15);
    expect_counts("post_rst", 1, 0, 0, 0);

    // Random activity with mixed run lengths
    clear_tally();
    lvl_i = 0;
    while (n < 10500) begin
      lvl_i = 1 - lvl_i;
      len = (($urandom % 4) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 12));
      run(lvl_i[0], len);
    end
    run(1'b0, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
